xorframe_pack: RTL
==================

# xorframe_pack

Upstream framing stage for the running-XOR executor. Collects a variable-length burst of payload bytes from a valid/ready/last source into an internal store-and-forward buffer. Once the burst closes, it pushes a length byte into the executor's input FIFO, followed by the buffered payload bytes, producing exactly the stream format the executor consumes.

## Interface
- `DWIDTH`, default 8: byte width of payload and length byte.
- `MAXLEN`, default 15: buffer depth, and maximum payload bytes per frame. Legal range 1..2^DWIDTH-1.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: source byte valid.
- `in_ready`  out  1: block accepts a source byte this cycle.
- `in_data`  in  DWIDTH: source byte.
- `in_last`  in  1: qualifies the final byte of a burst.
- `ofifo_push`  out  1: push `ofifo_data` into the executor input FIFO.
- `ofifo_not_full`  in  1: FIFO can take a push this cycle.
- `ofifo_data`  out  DWIDTH: length byte or payload byte.
- `ovf_err`  out  1: one-cycle pulse when a frame is force-closed at MAXLEN.
- `frame_cnt`  out  8: frames completed. Present only with `XORFRAME_FRAMECNT_EN`.

## Operation
The FSM has three states: FILL, LEN and DATA. Reset state is FILL.

FILL:
- `in_ready`=1.
- On `in_valid`:
  - store `in_data` at `buf[cnt]`;
  - `cnt` <= `cnt`+1.
- Close the frame and go to LEN when either condition holds:
  - `in_valid & in_last`;
  - the accepted byte makes `cnt`==MAXLEN.
- If the frame is closed by MAXLEN and `in_last` is 0, pulse `ovf_err`.
  - The remaining source bytes are not dropped; they form the next frame.

LEN:
- `ofifo_data`=`cnt`, zero-extended to DWIDTH.
- `ofifo_push`=`ofifo_not_full`.
- On push: `rd_ptr`<=0, then go to DATA.

DATA:
- `ofifo_data`=`buf[rd_ptr]`.
- `ofifo_push`=`ofifo_not_full`.
- On push: `rd_ptr`++.
- On the push of byte `cnt`-1:
  - `cnt`<=0;
  - increment `frame_cnt`, which wraps 255->0;
  - go to FILL.

Rules:
- `ofifo_push` is never asserted while `ofifo_not_full`=0.
- `ofifo_push` is never asserted in FILL.
- `in_ready` is 0 in LEN and DATA. The source is fully back-pressured while a frame drains; there is no overlap of fill and drain.
- Zero-length frames cannot occur: the first accepted byte makes `cnt`>=1.
- `ofifo_not_full` deasserting mid-frame stalls in place. `rd_ptr`, `ofifo_data` and state are held.
- Reset:
  - reset mid-operation discards the buffered frame; no partial length or payload is emitted;
  - `cnt`, `rd_ptr`, `frame_cnt` clear to 0.

## Timing
Reset values, and values while `rst`=1:
- `in_ready`=0. Forced low during reset even though the state is FILL.
- `ofifo_push`=0, `ovf_err`=0, `frame_cnt`=0.
- `ofifo_data`=0.

Output timing:
- `in_ready`, `ofifo_push` and `ofifo_data` are combinational from state, registers and `ofifo_not_full`. There is no dependency on `in_valid`.
- `ovf_err` is registered; it is high the cycle after the closing accept.

Latency and throughput:
- Last byte accepted at cycle t: length byte pushed at t+1 at the earliest; payload pushed at t+2..t+1+N.
- The first byte of the next frame is accepted at t+2+N at the earliest.
- With no back-pressure, throughput is N payload bytes per 2N+1 cycles.

## Configuration
- `XORFRAME_FRAMECNT_EN` defined: the `frame_cnt` port and its 8-bit counter exist. It increments on the final payload push of each frame.
- Not defined: neither the port nor the counter exists. All other behaviour is identical.

## Test plan
- Burst 0x16,0x05,0x08,0xFF with `in_last` on 0xFF, `ofifo_not_full`=1.
  - Pushes 0x04,0x16,0x05,0x08,0xFF on consecutive cycles starting the cycle after 0xFF is accepted.
  - `frame_cnt`=1.
- Single byte 0x44 with `in_last`: pushes 0x01,0x44; `in_ready` returns high 3 cycles after the accept.
- 17 bytes without `in_last` (MAXLEN=15), with the 17th byte carrying `in_last`:
  - 15-byte frame (0x0F length), with `ovf_err` pulsed once;
  - then a 2-byte frame (0x02 length);
  - `in_ready`=0 throughout each drain.
- `ofifo_not_full` low for 3 cycles after the second payload push:
  - no push during the stall, `ofifo_data` holds byte 3;
  - the remaining bytes resume in order.
- `rst` asserted in DATA after 2 of 4 payload bytes:
  - no further pushes;
  - after reset a new burst 0x03,0x09 (last) yields exactly 0x02,0x03,0x09.
- With the macro: 256 single-byte frames -> `frame_cnt` wraps to 0. Without the macro: same stream compiles and matches byte-for-byte.

Source files
------------

// File: rtl/xorframe_pack.sv
// xorframe_pack: store-and-forward framer for the running-XOR executor.
// Collects a valid/ready/last burst into a local buffer, then emits a length
// byte followed by the buffered payload into the executor's input FIFO.
// Frames are force-closed at MAXLEN bytes, which pulses ovf_err.
// Optional: define XORFRAME_FRAMECNT_EN to add the 8-bit frame_cnt port and
// counter of completed frames.
module xorframe_pack #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned MAXLEN = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              ofifo_push,
  input  logic              ofifo_not_full,
  output logic [DWIDTH-1:0] ofifo_data,
  output logic              ovf_err
`ifdef XORFRAME_FRAMECNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);

  // Wide enough to hold the byte count MAXLEN itself.
  localparam int unsigned CW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_LEN,
    S_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;
  logic [DWIDTH-1:0] mem_q [MAXLEN];
  logic              at_max;
  logic              last_rd;

`ifdef XORFRAME_FRAMECNT_EN
  logic [7:0]        fcnt_q, fcnt_d;
  assign frame_cnt = fcnt_q;
`endif

  assign ovf_err = ovf_q;
  // The byte being accepted now fills the buffer.
  assign at_max  = (cnt_q == CW'(MAXLEN - 1));
  // The payload byte at rd_ptr is the final one of the frame.
  assign last_rd = (rd_ptr_q == (cnt_q - CW'(1)));

  // Next-state, counters and all combinational handshake/data outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = 1'b0;
    wr_en      = 1'b0;
    in_ready   = 1'b0;
    ofifo_push = 1'b0;
    ofifo_data = '0;
`ifdef XORFRAME_FRAMECNT_EN
    fcnt_d     = fcnt_q;
`endif
    unique case (state_q)
      S_FILL: begin
        in_ready = ~rst;
        if (in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (in_last || at_max) begin
            state_d = S_LEN;
            ovf_d   = at_max & ~in_last;
          end
        end
      end
      S_LEN: begin
        ofifo_data = DWIDTH'(cnt_q);
        ofifo_push = ofifo_not_full & ~rst;
        if (ofifo_push) begin
          rd_ptr_d = '0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        ofifo_data = mem_q[rd_ptr_q];
        ofifo_push = ofifo_not_full & ~rst;
        if (ofifo_push) begin
          if (last_rd) begin
            cnt_d   = '0;
            state_d = S_FILL;
`ifdef XORFRAME_FRAMECNT_EN
            fcnt_d  = fcnt_q + 8'd1;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + CW'(1);
          end
        end
      end
      default: state_d = S_FILL;
    endcase
    if (rst) begin
      ofifo_data = '0;
    end
  end

  // State and control registers; synchronous reset discards any buffered frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FILL;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
`ifdef XORFRAME_FRAMECNT_EN
      fcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
`ifdef XORFRAME_FRAMECNT_EN
      fcnt_q   <= fcnt_d;
`endif
    end
  end

  // Payload buffer; written only while filling, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[cnt_q] <= in_data;
    end
  end

endmodule
